// File: rtl/pcu_pkg.sv
// Shared types and constants for the program-counter unit.
package pcu_pkg;

    typedef enum logic [1:0] {
        SETTLE,
        RUN,
        HALT
    } pcu_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_TRAP,
        SRC_FLUSH
    } redir_src_e;

    localparam int ILEN_BYTES = 4;
    localparam int ALIGN_LSB  = 2;
    localparam int BTB_FW     = 32;

    typedef struct packed {
        logic              valid;
        logic [BTB_FW-1:0] tag;
        logic [BTB_FW-1:0] tgt;
    } btb_entry_t;

    function automatic int align_lsb(input int ilen);
        return $clog2(ilen / 8);
    endfunction

endpackage

// File: rtl/pcu_btb.sv
// Direct-mapped branch target buffer: combinational lookup, edge update.
// Updates land at the clock edge, so a same-cycle lookup sees old contents.
module pcu_btb
    import pcu_pkg::*;
#(
    parameter int AW    = 32,
    parameter int ALSB  = ALIGN_LSB,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_lkp_pc,
    output logic          o_hit,
    output logic [AW-1:0] o_tgt,
    input  logic          i_upd_valid,
    input  logic [AW-1:0] i_upd_pc,
    input  logic [AW-1:0] i_upd_tgt,
    input  logic          i_upd_taken
);

    localparam int IDX = $clog2(DEPTH);

    btb_entry_t r_tab [DEPTH];

    logic [IDX-1:0]    w_lidx;
    logic [IDX-1:0]    w_uidx;
    logic [BTB_FW-1:0] w_ltag;
    logic [BTB_FW-1:0] w_utag;
    logic              w_umatch;

    assign w_lidx = IDX'(i_lkp_pc >> ALSB);
    assign w_uidx = IDX'(i_upd_pc >> ALSB);
    assign w_ltag = BTB_FW'(i_lkp_pc >> (ALSB + IDX));
    assign w_utag = BTB_FW'(i_upd_pc >> (ALSB + IDX));

    assign o_hit = r_tab[w_lidx].valid
                && (r_tab[w_lidx].tag == w_ltag);
    assign o_tgt = r_tab[w_lidx].tgt[AW-1:0];

    assign w_umatch = r_tab[w_uidx].valid
                   && (r_tab[w_uidx].tag == w_utag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab[i].valid <= 1'b0;
            end
        end else if (i_upd_valid) begin
            if (i_upd_taken) begin
                r_tab[w_uidx] <= '{
                    valid: 1'b1,
                    tag:   w_utag,
                    tgt:   BTB_FW'(i_upd_tgt)
                };
            end else if (w_umatch) begin
                r_tab[w_uidx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcu_redirect.sv
// Program-counter unit: reset settle, fetch handshake, trap/flush redirect, halt.
// Define PCU_BTB_EN to add BTB next-PC prediction.
module pcu_redirect
    import pcu_pkg::*;
#(
    parameter int            AW          = 32,
    parameter int            ILEN        = ILEN_BYTES * 8,
    parameter logic [AW-1:0] RESET_PC    = '0,
    parameter int            RESET_CNT_W = 3,
    parameter int            BTB_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_trap_valid,
    input  logic [AW-1:0] i_trap_pc,
    input  logic          i_flush_valid,
    input  logic [AW-1:0] i_flush_pc,
    input  logic          i_halt,
    input  logic          i_resume,
    input  logic          i_pc_ready,
    output logic          o_pc_valid,
    output logic [AW-1:0] o_pc,
    output logic          o_pred_taken,
    output logic          o_misalign,
    input  logic          i_btb_upd_valid,
    input  logic [AW-1:0] i_btb_upd_pc,
    input  logic [AW-1:0] i_btb_upd_tgt,
    input  logic          i_btb_upd_taken
);

    localparam int            LSB  = align_lsb(ILEN);
    localparam logic [AW-1:0] STEP = AW'(ILEN / 8);

    pcu_state_e             r_state;
    pcu_state_e             w_state_nxt;
    logic [RESET_CNT_W-1:0] r_cnt;
    logic [RESET_CNT_W-1:0] w_cnt_nxt;
    logic [AW-1:0]          r_pc;
    logic [AW-1:0]          w_pc_nxt;
    logic                   r_misalign;
    logic                   w_mis_nxt;

    redir_src_e    w_src;
    logic [AW-1:0] w_raw;
    logic [AW-1:0] w_tgt;
    logic          w_raw_mis;
    logic          w_redir;
    logic          w_fire;
    logic          w_hit;
    logic [AW-1:0] w_btb_tgt;

    assign o_pc_valid = (r_state == RUN);
    assign o_pc       = r_pc;
    assign o_misalign = r_misalign;
    assign w_fire     = o_pc_valid & i_pc_ready;

`ifdef PCU_BTB_EN
    pcu_btb #(
        .AW    (AW),
        .ALSB  (LSB),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_lkp_pc    (r_pc),
        .o_hit       (w_hit),
        .o_tgt       (w_btb_tgt),
        .i_upd_valid (i_btb_upd_valid
                      && (r_state != SETTLE)),
        .i_upd_pc    (i_btb_upd_pc),
        .i_upd_tgt   (i_btb_upd_tgt),
        .i_upd_taken (i_btb_upd_taken)
    );
`else
    logic w_unused;
    assign w_unused  = ^{i_btb_upd_valid, i_btb_upd_pc,
                         i_btb_upd_tgt, i_btb_upd_taken,
                         (BTB_DEPTH != 0)};
    assign w_hit     = 1'b0;
    assign w_btb_tgt = '0;
`endif

    assign o_pred_taken = o_pc_valid & w_hit;

    // Trap outranks flush; low bits are dropped but remembered.
    always_comb begin
        w_src = SRC_NONE;
        w_raw = '0;
        if (i_trap_valid) begin
            w_src = SRC_TRAP;
            w_raw = i_trap_pc;
        end else if (i_flush_valid) begin
            w_src = SRC_FLUSH;
            w_raw = i_flush_pc;
        end
    end

    assign w_redir   = (w_src != SRC_NONE);
    assign w_tgt     = {w_raw[AW-1:LSB], {LSB{1'b0}}};
    assign w_raw_mis = |w_raw[LSB-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = r_pc;
        w_mis_nxt   = 1'b0;
        unique case (r_state)
            SETTLE: begin
                if (&r_cnt) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (w_redir) begin
                    w_pc_nxt  = w_tgt;
                    w_mis_nxt = w_raw_mis;
                end else if (w_fire && w_hit) begin
                    w_pc_nxt = {w_btb_tgt[AW-1:LSB],
                                {LSB{1'b0}}};
                end else if (w_fire) begin
                    w_pc_nxt = r_pc + STEP;
                end
                if (i_halt) begin
                    w_state_nxt = HALT;
                end
            end
            HALT: begin
                if (w_redir) begin
                    w_pc_nxt    = w_tgt;
                    w_mis_nxt   = w_raw_mis;
                    w_state_nxt = RUN;
                end else if (i_resume) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SETTLE;
            r_cnt      <= '0;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= w_mis_nxt;
        end
    end

endmodule

// File: tb/tb_pcu_redirect.sv
// Directed bench for pcu_redirect; BTB steps compile in with PCU_BTB_EN.
`timescale 1ns/1ps
module tb_pcu_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_v, flush_v, halt, resume, ready;
    logic [31:0] trap_pc, flush_pc;
    logic        pc_valid, pred, mis;
    logic [31:0] pc;
    logic        upd_v, upd_taken;
    logic [31:0] upd_pc, upd_tgt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pcu_redirect dut (
        .clk             (clk),
        .rst             (rst),
        .i_trap_valid    (trap_v),
        .i_trap_pc       (trap_pc),
        .i_flush_valid   (flush_v),
        .i_flush_pc      (flush_pc),
        .i_halt          (halt),
        .i_resume        (resume),
        .i_pc_ready      (ready),
        .o_pc_valid      (pc_valid),
        .o_pc            (pc),
        .o_pred_taken    (pred),
        .o_misalign      (mis),
        .i_btb_upd_valid (upd_v),
        .i_btb_upd_pc    (upd_pc),
        .i_btb_upd_tgt   (upd_tgt),
        .i_btb_upd_taken (upd_taken)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_run(input string tag,
                           input logic [31:0] exp_pc);
        chk({tag, "_valid"}, 32'(pc_valid), 32'd1);
        chk({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        rst = 1; trap_v = 0; flush_v = 0; halt = 0;
        resume = 0; ready = 1; trap_pc = 0; flush_pc = 0;
        upd_v = 0; upd_taken = 0; upd_pc = 0; upd_tgt = 0;
        tick(); tick();
        chk("rst_valid", 32'(pc_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pred", 32'(pred), 32'd0);
        chk("rst_mis", 32'(mis), 32'd0);

        // settle: 8 low cycles, then 0,4,8,C
        rst = 0;
        chk("settle_0", 32'(pc_valid), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("settle_n", 32'(pc_valid), 32'd0);
        end
        tick(); chk_run("seq0", 32'h0);
        tick(); chk_run("seq4", 32'h4);
        tick(); chk_run("seq8", 32'h8);
        tick(); chk_run("seqC", 32'hC);
        tick(); chk_run("seq10", 32'h10);

        // backpressure holds the PC
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_run("stall", 32'h10);
        end
        ready = 1;
        tick(); chk_run("unstall", 32'h14);

        // trap beats flush
        trap_v = 1; trap_pc = 32'h100;
        flush_v = 1; flush_pc = 32'h200;
        tick(); chk_run("trap_prio", 32'h100);
        chk("trap_mis", 32'(mis), 32'd0);
        trap_v = 0;

        // misaligned flush target
        flush_pc = 32'h203;
        tick(); chk_run("flush_mis", 32'h200);
        chk("mis_pulse", 32'(mis), 32'd1);
        flush_v = 0;
        tick(); chk_run("after_mis", 32'h204);
        chk("mis_clear", 32'(mis), 32'd0);

        // halt with fire at 0x40, then resume
        trap_v = 1; trap_pc = 32'h40;
        tick(); chk_run("to40", 32'h40);
        trap_v = 0; halt = 1;
        tick();
        chk("halt_valid", 32'(pc_valid), 32'd0);
        chk("halt_pc", pc, 32'h44);
        halt = 0;
        tick();
        chk("halt_hold_v", 32'(pc_valid), 32'd0);
        chk("halt_hold_pc", pc, 32'h44);
        resume = 1;
        tick(); chk_run("resume", 32'h44);
        resume = 0;
        tick(); chk_run("resume_seq", 32'h48);

        // redirect + halt together, then redirect out of HALT
        flush_v = 1; flush_pc = 32'h300; halt = 1;
        tick();
        chk("rh_valid", 32'(pc_valid), 32'd0);
        chk("rh_pc", pc, 32'h300);
        halt = 0; flush_pc = 32'h400;
        tick(); chk_run("halt_redir", 32'h400);
        flush_v = 0;

        // wrap at top of address space
        trap_v = 1; trap_pc = 32'hFFFF_FFFC;
        tick(); chk_run("top", 32'hFFFF_FFFC);
        trap_v = 0;
        tick(); chk_run("wrap", 32'h0);

        // misaligned trap, and redirect while not ready
        trap_v = 1; trap_pc = 32'h102; ready = 0;
        tick(); chk_run("trap_mis_pc", 32'h100);
        chk("trap_mis_p", 32'(mis), 32'd1);
        trap_v = 0; flush_v = 1; flush_pc = 32'h500;
        tick(); chk_run("nrdy_redir", 32'h500);
        flush_v = 0;
        tick(); chk_run("nrdy_hold", 32'h500);
        ready = 1;

        // reset dominates a trap; redirects ignored while settling
        rst = 1; trap_v = 1; trap_pc = 32'h700;
        tick();
        chk("rst_dom_v", 32'(pc_valid), 32'd0);
        chk("rst_dom_pc", pc, 32'h0);
        rst = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("settle_ign", pc, 32'h0);
        end
        trap_v = 0;
        tick(); chk_run("resettle", 32'h0);

`ifdef PCU_BTB_EN
        // install 0x20 -> 0x80 while holding at 0
        ready = 0;
        upd_v = 1; upd_taken = 1;
        upd_pc = 32'h20; upd_tgt = 32'h80;
        tick(); chk_run("upd_hold", 32'h0);
        upd_v = 0;
        flush_v = 1; flush_pc = 32'h20;
        tick(); chk_run("at20", 32'h20);
        chk("pred20", 32'(pred), 32'd1);
        flush_v = 0; ready = 1;
        tick(); chk_run("btb_jump", 32'h80);
        chk("pred80", 32'(pred), 32'd0);

        // reset wipes the BTB
        rst = 1;
        tick();
        chk("btb_rst_pred", 32'(pred), 32'd0);
        rst = 0;
        for (int i = 0; i < 8; i++) tick();
        flush_v = 1; flush_pc = 32'h20;
        tick(); chk_run("rst20", 32'h20);
        chk("rst_nopred", 32'(pred), 32'd0);
        flush_v = 0;
        tick(); chk_run("rst_seq", 32'h24);

        // same-cycle invalidate still sees the old entry
        ready = 0;
        upd_v = 1; upd_taken = 1;
        upd_pc = 32'h20; upd_tgt = 32'h80;
        flush_v = 1; flush_pc = 32'h20;
        tick(); chk_run("re20", 32'h20);
        chk("re_pred", 32'(pred), 32'd1);
        flush_v = 0; ready = 1; upd_taken = 0;
        tick(); chk_run("old_contents", 32'h80);
        upd_v = 0;
        flush_v = 1;
        tick(); chk_run("inv20", 32'h20);
        chk("inv_pred", 32'(pred), 32'd0);
        flush_v = 0;
`else
        // no BTB: updates never produce a prediction
        upd_v = 1; upd_taken = 1;
        upd_pc = 32'h20; upd_tgt = 32'h80;
        flush_v = 1; flush_pc = 32'h20;
        tick(); chk_run("at20", 32'h20);
        chk("nobtb_pred", 32'(pred), 32'd0);
        flush_v = 0; upd_v = 0;
        tick(); chk_run("nobtb_seq", 32'h24);
        chk("nobtb_pred2", 32'(pred), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
